// File: rtl/stream_pipe_pkg.sv
// Shared definitions for the stream_pipe_mux slice.
//   DEF_DATA_W / DEF_DEPTH / DEF_NUM_CH : default build parameters
//   ch_w() / cnt_w()                    : width helpers for channel tag and occupancy
//   CH_W / CNT_W                        : helper widths for the default parameters
//   entry_t                             : buffer entry layout {ch, data[, parity]}
// Optional macro STREAM_PIPE_PARITY_EN adds the stored parity bit to each entry.
package stream_pipe_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_NUM_CH = 2;

  // A single channel still gets a 1-bit tag (tied to 0).
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned CH_W  = ch_w(DEF_NUM_CH);
  localparam int unsigned CNT_W = cnt_w(DEF_DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DEF_DATA_W-1:0] data;
`ifdef STREAM_PIPE_PARITY_EN
    logic                  parity;
`endif
  } entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for stream_pipe_mux.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   req        : per-channel request (in_valid)
//   advance    : a grant was consumed this cycle (push)
//   adv_idx    : index of the consumed grant; becomes the new last pointer
//   grant      : one-hot grant, first requester after last with wrap; 0 if none
//   index      : binary index of grant (0 when no requester)
module rr_arbiter
  import stream_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      advance,
  input  logic [ch_w(NUM_CH)-1:0]   adv_idx,
  output logic [NUM_CH-1:0]         grant,
  output logic [ch_w(NUM_CH)-1:0]   index
);

  localparam int unsigned IdxW = ch_w(NUM_CH);

  logic [IdxW-1:0] last_q;

  // Reset to the highest channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IdxW'(NUM_CH - 1);
    end else if (advance) begin
      last_q <= adv_idx;
    end
  end

  always_comb begin
    logic found;
    int   cand;
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      cand = (int'(last_q) + k) % int'(NUM_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_pipe_mux.sv
// Multi-channel stream merge into a first-word-fall-through buffer.
// NUM_CH valid/ready inputs are arbitrated round-robin; the winner's word is stored
// with its channel tag and drained through a single valid/ready output.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : per-channel handshake; channel i data at in_data[i*DATA_W +: DATA_W]
//   out_valid/out_ready : output handshake; out_data/out_ch read from the head entry
//   count, full, empty  : buffer occupancy
// Optional macro STREAM_PIPE_PARITY_EN adds per-entry even parity plus the
// parity_err (head check) and err_sticky (error popped since reset) outputs.
module stream_pipe_mux
  import stream_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NUM_CH = DEF_NUM_CH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ch_w(NUM_CH)-1:0]    out_ch,
  input  logic                       out_ready,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       full,
  output logic                       empty
`ifdef STREAM_PIPE_PARITY_EN
  ,
  output logic                       parity_err,
  output logic                       err_sticky
`endif
);

  localparam int unsigned ChW  = ch_w(NUM_CH);
  localparam int unsigned CntW = cnt_w(DEPTH);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef struct packed {
    logic [ChW-1:0]    ch;
    logic [DATA_W-1:0] data;
`ifdef STREAM_PIPE_PARITY_EN
    logic              parity;
`endif
  } slot_t;

  slot_t           mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  logic [NUM_CH-1:0] grant;
  logic [ChW-1:0]    gnt_idx;
  logic              push, pop;
  slot_t             wr_entry, head;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (in_valid),
    .advance (push),
    .adv_idx (gnt_idx),
    .grant   (grant),
    .index   (gnt_idx)
  );

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // No bypass when full: in_ready is independent of out_ready.
  assign in_ready = grant & {NUM_CH{~full & ~reset}};
  assign push     = |(in_valid & in_ready);
  assign pop      = out_valid & out_ready;

  always_comb begin
    wr_entry      = '0;
    wr_entry.ch   = gnt_idx;
    wr_entry.data = in_data[gnt_idx*DATA_W +: DATA_W];
`ifdef STREAM_PIPE_PARITY_EN
    wr_entry.parity = ^in_data[gnt_idx*DATA_W +: DATA_W];
`endif
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = ~empty;
  assign out_data  = head.data;
  assign out_ch    = head.ch;

  // Storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef STREAM_PIPE_PARITY_EN
  logic err_sticky_q;

  assign parity_err = out_valid & (head.parity != ^head.data);
  assign err_sticky = err_sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
    end else if (pop && parity_err) begin
      err_sticky_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_pipe_mux.sv
// Self-checking bench for stream_pipe_mux (DATA_W=8, DEPTH=4, NUM_CH=2).
// A queue-based model of the buffer plus a round-robin pick rule is compared to the
// DUT every cycle; directed phases add literal expectations that pin the model.
module tb_stream_pipe_mux;

  localparam int DW   = 8;
  localparam int DP   = 4;
  localparam int NC   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]   in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [0:0]      out_ch;
  logic            out_ready;
  logic [2:0]      count;
  logic            full;
  logic            empty;
`ifdef STREAM_PIPE_PARITY_EN
  logic            parity_err;
  logic            err_sticky;
`endif

  stream_pipe_mux #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .NUM_CH (NC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef STREAM_PIPE_PARITY_EN
    ,
    .parity_err (parity_err),
    .err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stored words as {ch, data}, and the last granted channel.
  logic [DW:0] mq[$];
  int          mlast = NC - 1;
  logic [DW:0] popped[$];
  logic        chk_en = 1'b0;

  always @(negedge clk) begin
    int            g;
    logic [NC-1:0] exp_rdy;
    logic          m_push, m_pop;
    g = -1;
    for (int k = 1; k <= NC; k++) begin
      if (g < 0 && in_valid[(mlast + k) % NC]) g = (mlast + k) % NC;
    end
    exp_rdy = '0;
    if (!reset && mq.size() < DP && g >= 0) exp_rdy[g] = 1'b1;
    m_push = (g >= 0) && exp_rdy[g];
    m_pop  = !reset && mq.size() > 0 && out_ready;
    if (chk_en) begin
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DP);
      check("out_valid", out_valid, mq.size() > 0);
      check("in_ready", in_ready, exp_rdy);
      if (mq.size() > 0) begin
        check("out_data", out_data, mq[0][DW-1:0]);
        check("out_ch", out_ch, mq[0][DW]);
      end
`ifdef STREAM_PIPE_PARITY_EN
      check("parity_err", parity_err, 0);
      check("err_sticky", err_sticky, 0);
`endif
      if (m_pop) popped.push_back({out_ch, out_data});
    end
    if (reset) begin
      mq.delete();
      mlast = NC - 1;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back({1'(g), in_data[g*DW +: DW]});
        mlast = g;
      end
    end
  end

  // Handshakes accepted at the coming edge, as seen by the sender.
  logic [NC-1:0] acc;

  task automatic step();
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
  endtask

  int n;
  int rdy_pct;

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    acc       = '0;

    // Reset and idle
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    check("idle_out_valid", out_valid, 0);
    check("idle_empty", empty, 1);
    check("idle_count", count, 0);
    check("idle_in_ready", in_ready, 2'b00);

    // Both channels streaming: ch0 first, then alternate
    popped.delete();
    in_valid  = 2'b11;
    in_data   = {8'hA1, 8'h11};
    out_ready = 1'b1;
    repeat (12) begin
      step();
      for (int i = 0; i < NC; i++)
        if (acc[i]) in_data[i*DW +: DW] = in_data[i*DW +: DW] + 8'd1;
    end
    in_valid = 2'b00;
    check("alt_0", popped[0], 9'h011);
    check("alt_1", popped[1], 9'h1A1);
    check("alt_2", popped[2], 9'h012);
    check("alt_3", popped[3], 9'h1A2);
    repeat (4) step();

    // Single word from ch1: visible one cycle after the push
    in_valid = 2'b10;
    in_data[15:8] = 8'h5A;
    step();
    in_valid = 2'b00;
    check("ch1_valid", out_valid, 1);
    check("ch1_data", out_data, 8'h5A);
    check("ch1_ch", out_ch, 1);
    check("ch1_count", count, 1);
    step();
    check("ch1_drained", count, 0);

    // Fill to full with out_ready low; fifth word waits
    out_ready = 1'b0;
    in_valid  = 2'b01;
    in_data[7:0] = 8'h31;
    n = 0;
    repeat (6) begin
      step();
      if (acc[0]) begin
        n++;
        in_data[7:0] = in_data[7:0] + 8'd1;
      end
    end
    check("full_accepted", n, 4);
    check("full_flag", full, 1);
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 2'b00);
    check("full_head", out_data, 8'h31);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("after_pop_count", count, 3);
    check("after_pop_ready", in_ready, 2'b01);
    check("after_pop_head", out_data, 8'h32);
    step();
    check("held_accepted", acc[0], 1);
    in_valid = 2'b00;
    check("refill_count", count, 4);
    out_ready = 1'b1;
    repeat (5) step();
    check("drain_empty", empty, 1);

    // Reset mid-stream at count 3
    out_ready = 1'b0;
    in_valid  = 2'b11;
    in_data   = {8'hB0, 8'h40};
    repeat (3) begin
      step();
      for (int i = 0; i < NC; i++)
        if (acc[i]) in_data[i*DW +: DW] = in_data[i*DW +: DW] + 8'd1;
    end
    check("pre_reset_count", count, 3);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 2'b00;
    check("mid_reset_count", count, 0);
    check("mid_reset_valid", out_valid, 0);
    step();

    // Simultaneous push and pop at count 1 across pointer wrap
    in_valid = 2'b01;
    in_data[7:0] = 8'h60;
    step();
    if (acc[0]) in_data[7:0] = in_data[7:0] + 8'd1;
    out_ready = 1'b1;
    popped.delete();
    repeat (10) begin
      step();
      if (acc[0]) in_data[7:0] = in_data[7:0] + 8'd1;
      check("steady_count", count, 1);
    end
    in_valid = 2'b00;
    check("steady_order_0", popped[0], 9'h060);
    check("steady_order_9", popped[9], 9'h069);
    repeat (2) step();

    // Randomized traffic with occasional resets
    rdy_pct = 55;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rdy_pct = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 55 : 90);
      for (int i = 0; i < NC; i++) begin
        if (!in_valid[i] || acc[i]) begin
          in_valid[i] = $urandom_range(0, 99) < 60;
          in_data[i*DW +: DW] = 8'($urandom);
        end
      end
      out_ready = $urandom_range(0, 99) < rdy_pct;
      reset     = $urandom_range(0, 299) == 0;
      step();
    end
    reset    = 1'b0;
    in_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
